// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receiver, transmitter, ALU and the
//   uart_alu_if control stage.
//   - Default data and opcode widths, so every block agrees on the byte format.
//   - Default inter-byte timeout settings.
//   - 3-bit state encodings of the control FSM and the matching enum type.
//   - is_busy_state(): the states in which a new frame cannot be accepted.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DBIT_DEF      = 8;
    localparam int NB_OP_DEF     = 6;
    localparam int TO_CYCLES_DEF = 50000;
    localparam int NB_TO_DEF     = 16;

    localparam logic [2:0] ST_WAIT_A    = 3'd0;
    localparam logic [2:0] ST_WAIT_B    = 3'd1;
    localparam logic [2:0] ST_WAIT_OP   = 3'd2;
    localparam logic [2:0] ST_CALC      = 3'd3;
    localparam logic [2:0] ST_SEND      = 3'd4;
    localparam logic [2:0] ST_WAIT_DONE = 3'd5;

    typedef enum logic [2:0] {
        WAIT_A    = ST_WAIT_A,
        WAIT_B    = ST_WAIT_B,
        WAIT_OP   = ST_WAIT_OP,
        CALC      = ST_CALC,
        SEND      = ST_SEND,
        WAIT_DONE = ST_WAIT_DONE
    } state_t;

    // A frame has been collected and is being computed or sent.
    function automatic logic is_busy_state(input state_t s);
        return (s == CALC) || (s == SEND) || (s == WAIT_DONE);
    endfunction

endpackage

// File: rtl/uart_alu_if_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
//   Inter-byte timeout counter for the uart_alu_if control stage.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst    asynchronous reset, active-low (counter to 0)
//     clr      synchronous clear to 0 (wins over en)
//     en       count one cycle
//     expired  high while the count equals TO_CYCLES-1
// -----------------------------------------------------------------------------
module frame_timer #(
    parameter int TO_CYCLES = 50000,
    parameter int NB_TO     = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [NB_TO-1:0] LAST_COUNT = NB_TO'(TO_CYCLES - 1);

    logic [NB_TO-1:0] count_reg;
    logic [NB_TO-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_reg + NB_TO'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (count_reg == LAST_COUNT);

endmodule

// File: rtl/uart_alu_if.sv
// -----------------------------------------------------------------------------
// uart_alu_if
//   Control stage between UART rx and tx. Collects operand A, operand B and an
//   opcode byte from rx, presents them to an external combinational ALU,
//   captures the result and hands it to tx with a one-cycle start pulse, then
//   waits for tx to report completion. A partial frame is discarded when the
//   gap between two of its bytes exceeds TO_CYCLES cycles.
//   Ports:
//     i_clk         clock, rising edge
//     i_rst         asynchronous reset, active-low
//     i_rx_done     one-cycle pulse, i_rx_data holds a new byte
//     i_rx_data     received byte
//     i_alu_result  combinational ALU result for o_data_a/o_data_b/o_opcode
//     i_tx_done     one-cycle pulse from tx, stop bit finished
//     o_data_a      operand A to ALU
//     o_data_b      operand B to ALU
//     o_opcode      opcode to ALU (low NB_OP bits of the third byte)
//     o_tx_start    one-cycle pulse, tx loads o_tx_data
//     o_tx_data     captured result, stable until i_tx_done
//     o_busy        high while computing/sending (CALC, SEND, WAIT_DONE)
//     o_drop        one-cycle pulse, an rx byte was discarded while busy
//   All outputs are registered.
// -----------------------------------------------------------------------------
module uart_alu_if
    import uart_pkg::*;
#(
    parameter int DBIT      = DBIT_DEF,
    parameter int NB_OP     = NB_OP_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF,
    parameter int NB_TO     = NB_TO_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_done,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic [DBIT-1:0]  i_alu_result,
    input  logic             i_tx_done,
    output logic [DBIT-1:0]  o_data_a,
    output logic [DBIT-1:0]  o_data_b,
    output logic [NB_OP-1:0] o_opcode,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_drop
);

    state_t            state_reg,    state_next;
    logic [DBIT-1:0]   data_a_reg,   data_a_next;
    logic [DBIT-1:0]   data_b_reg,   data_b_next;
    logic [NB_OP-1:0]  opcode_reg,   opcode_next;
    logic [DBIT-1:0]   tx_data_reg,  tx_data_next;
    logic              tx_start_reg, tx_start_next;
    logic              busy_reg,     busy_next;
    logic              drop_reg,     drop_next;

    logic              timer_en;
    logic              timer_clr;
    logic              timer_expired;

    // The opcode keeps only the low NB_OP bits of the byte; the upper bits are
    // deliberately thrown away.
    generate
        if (NB_OP < DBIT) begin : g_op_trunc
            logic unused_op_hi_bits;
            assign unused_op_hi_bits = ^i_rx_data[DBIT-1:NB_OP];
        end
    endgenerate

    // The timer only runs while waiting for the 2nd or 3rd byte of a frame and
    // nothing arrived this cycle; in every other case it is held at zero, so it
    // always starts a fresh gap from 0.
    assign timer_clr = !timer_en;

    frame_timer #(
        .TO_CYCLES (TO_CYCLES),
        .NB_TO     (NB_TO)
    ) u_frame_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_next    = state_reg;
        data_a_next   = data_a_reg;
        data_b_next   = data_b_reg;
        opcode_next   = opcode_reg;
        tx_data_next  = tx_data_reg;
        tx_start_next = 1'b0;
        drop_next     = 1'b0;
        timer_en      = 1'b0;

        case (state_reg)
            WAIT_A: begin
                if (i_rx_done) begin
                    data_a_next = i_rx_data;
                    state_next  = WAIT_B;
                end
            end

            // A byte in the expiry cycle takes priority over the timeout.
            WAIT_B: begin
                if (i_rx_done) begin
                    data_b_next = i_rx_data;
                    state_next  = WAIT_OP;
                end else if (timer_expired) begin
                    state_next = WAIT_A;
                end else begin
                    timer_en = 1'b1;
                end
            end

            WAIT_OP: begin
                if (i_rx_done) begin
                    opcode_next = i_rx_data[NB_OP-1:0];
                    state_next  = CALC;
                end else if (timer_expired) begin
                    state_next = WAIT_A;
                end else begin
                    timer_en = 1'b1;
                end
            end

            // The ALU has had a full cycle to settle on the new opcode.
            CALC: begin
                tx_data_next  = i_alu_result;
                tx_start_next = 1'b1;
                drop_next     = i_rx_done;
                state_next    = SEND;
            end

            SEND: begin
                drop_next  = i_rx_done;
                state_next = WAIT_DONE;
            end

            // A byte coinciding with tx completion still belongs to the busy
            // period and is dropped.
            WAIT_DONE: begin
                drop_next = i_rx_done;
                if (i_tx_done) begin
                    state_next = WAIT_A;
                end
            end

            default: begin
                state_next = WAIT_A;
            end
        endcase

        busy_next = is_busy_state(state_next);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg    <= WAIT_A;
            data_a_reg   <= '0;
            data_b_reg   <= '0;
            opcode_reg   <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            busy_reg     <= 1'b0;
            drop_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            data_a_reg   <= data_a_next;
            data_b_reg   <= data_b_next;
            opcode_reg   <= opcode_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            busy_reg     <= busy_next;
            drop_reg     <= drop_next;
        end
    end

    assign o_data_a   = data_a_reg;
    assign o_data_b   = data_b_reg;
    assign o_opcode   = opcode_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_tx_start = tx_start_reg;
    assign o_busy     = busy_reg;
    assign o_drop     = drop_reg;

endmodule

// File: tb/tb_uart_alu_if.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_if
//   Self-checking bench for uart_alu_if with a short timeout. An external ALU
//   is modelled combinationally; expected results come from the bytes the
//   bench sent and the frame/timeout rules.
// -----------------------------------------------------------------------------
module tb_uart_alu_if;

    localparam int DBIT  = 8;
    localparam int NB_OP = 6;
    localparam int TO    = 16;
    localparam int NB_TO = 6;

    logic             clk;
    logic             rst;
    logic             rx_done;
    logic [DBIT-1:0]  rx_data;
    logic [DBIT-1:0]  alu_result;
    logic             tx_done;
    logic [DBIT-1:0]  data_a;
    logic [DBIT-1:0]  data_b;
    logic [NB_OP-1:0] opcode;
    logic             tx_start;
    logic [DBIT-1:0]  tx_data;
    logic             busy;
    logic             drop;

    int n_cmp = 0;
    int n_err = 0;

    uart_alu_if #(
        .DBIT      (DBIT),
        .NB_OP     (NB_OP),
        .TO_CYCLES (TO),
        .NB_TO     (NB_TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_data_a     (data_a),
        .o_data_b     (data_b),
        .o_opcode     (opcode),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_busy       (busy),
        .o_drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_f(data_a, data_b, opcode);

    // All driving/sampling happens 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_done = 1'b0; rx_data = '0; tx_done = 1'b0;
        idle(3);
        n_cmp++;
        if ({data_a, data_b, opcode, tx_start, tx_data, busy, drop} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got a=%h b=%h op=%h st=%b td=%h busy=%b drop=%b, want all 0",
                     data_a, data_b, opcode, tx_start, tx_data, busy, drop);
        end
        rst = 1'b1;
        step();
        $display("reset released");
    endtask

    task automatic test_add();
        pulse_rx(8'h05);
        pulse_rx(8'h03);
        pulse_rx(8'h20);
        n_cmp++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL add_calc_cycle: start=%b busy=%b, want start=0 busy=1", tx_start, busy);
        end
        step();
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== 8'h08) begin
            n_err++;
            $display("FAIL add_start: start=%b data=%h, want start=1 data=08", tx_start, tx_data);
        end
        step();
        n_cmp++;
        if (tx_start !== 1'b0 || tx_data !== 8'h08 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL add_wait_done: start=%b data=%h busy=%b, want 0/08/1", tx_start, tx_data, busy);
        end
        pulse_tx();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL add_idle: busy=%b want 0", busy);
        end
        $display("add frame 05+03 -> %h", tx_data);
    endtask

    task automatic test_drop();
        pulse_rx(8'h10);
        pulse_rx(8'h20);
        pulse_rx(8'h22);
        pulse_rx(8'h55);        // lands in CALC
        n_cmp++;
        if (tx_start !== 1'b1 || drop !== 1'b1 || tx_data !== 8'hF0) begin
            n_err++;
            $display("FAIL drop_calc: start=%b drop=%b data=%h, want 1/1/f0", tx_start, drop, tx_data);
        end
        step();
        pulse_rx(8'hAA);        // lands in WAIT_DONE
        n_cmp++;
        if (drop !== 1'b1 || data_a !== 8'h10 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL drop_wait_done: drop=%b a=%h busy=%b, want 1/10/1", drop, data_a, busy);
        end
        step();
        n_cmp++;
        if (drop !== 1'b0) begin
            n_err++;
            $display("FAIL drop_width: drop=%b want 0", drop);
        end
        pulse_tx();
        pulse_tx();             // outside WAIT_DONE: ignored
        pulse_rx(8'h07);
        pulse_tx();             // ignored while in WAIT_B
        pulse_rx(8'h0D);
        pulse_rx(8'h24);
        step();
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== 8'h05 || data_a !== 8'h07) begin
            n_err++;
            $display("FAIL drop_next_frame: start=%b data=%h a=%h, want 1/05/07", tx_start, tx_data, data_a);
        end
        step();
        rx_data = 8'h99; rx_done = 1'b1; tx_done = 1'b1;
        step();
        rx_done = 1'b0; tx_done = 1'b0;
        n_cmp++;
        if (drop !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drop_with_tx_done: drop=%b busy=%b, want 1/0", drop, busy);
        end
        $display("drop scenarios done");
    endtask

    task automatic test_timeout();
        pulse_rx(8'h11);
        pulse_rx(8'h22);
        idle(TO);
        n_cmp++;
        if (busy !== 1'b0 || data_a !== 8'h11 || data_b !== 8'h22) begin
            n_err++;
            $display("FAIL timeout_hold: busy=%b a=%h b=%h, want 0/11/22", busy, data_a, data_b);
        end
        pulse_rx(8'h01);
        pulse_rx(8'h02);
        pulse_rx(8'h20);
        step();
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== 8'h03 || opcode !== 6'h20) begin
            n_err++;
            $display("FAIL timeout_op_stage: start=%b data=%h op=%h, want 1/03/20", tx_start, tx_data, opcode);
        end
        step();
        pulse_tx();
        pulse_rx(8'h33);
        idle(TO);
        pulse_rx(8'h04);
        pulse_rx(8'h05);
        pulse_rx(8'h20);
        step();
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== 8'h09) begin
            n_err++;
            $display("FAIL timeout_b_stage: start=%b data=%h, want 1/09", tx_start, tx_data);
        end
        step();
        pulse_tx();
        $display("timeout frames done");
    endtask

    task automatic test_opcode_trunc();
        pulse_rx(8'h01);
        pulse_rx(8'h01);
        pulse_rx(8'hE2);
        n_cmp++;
        if (opcode !== 6'h22) begin
            n_err++;
            $display("FAIL opcode_trunc: op=%h want 22", opcode);
        end
        step();
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL opcode_trunc_result: start=%b data=%h, want 1/00", tx_start, tx_data);
        end
        step();
        pulse_tx();
        $display("opcode byte e2 -> %h", opcode);
    endtask

    task automatic test_reset_mid();
        int starts;
        pulse_rx(8'h40);
        pulse_rx(8'h02);
        pulse_rx(8'h20);
        idle(3);                // in WAIT_DONE
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if ({data_a, data_b, opcode, tx_start, tx_data, busy, drop} !== '0) begin
            n_err++;
            $display("FAIL reset_async_wait_done: a=%h b=%h op=%h st=%b td=%h busy=%b drop=%b",
                     data_a, data_b, opcode, tx_start, tx_data, busy, drop);
        end
        idle(2);
        rst = 1'b1;
        pulse_rx(8'h03);
        pulse_rx(8'h04);
        pulse_rx(8'h20);        // now in CALC
        rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || data_a !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async_calc: busy=%b a=%h, want 0/00", busy, data_a);
        end
        idle(2);
        rst = 1'b1;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (tx_start === 1'b1) starts++;
        end
        n_cmp++;
        if (starts !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_start: starts=%0d busy=%b, want 0/0", starts, busy);
        end
        $display("reset mid-frame done");
    endtask

    task automatic test_expiry_edge();
        pulse_rx(8'h0A);
        idle(TO - 1);           // B arrives in the expiry cycle
        pulse_rx(8'h0B);
        idle(TO - 1);           // opcode arrives in the expiry cycle
        pulse_rx(8'h20);
        step();
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== 8'h15 || data_a !== 8'h0A) begin
            n_err++;
            $display("FAIL expiry_edge: start=%b data=%h a=%h, want 1/15/0a", tx_start, tx_data, data_a);
        end
        step();
        pulse_tx();
        $display("expiry-cycle bytes accepted, result %h", tx_data);
    endtask

    // Reference: bytes form frames in order; a gap longer than TO cycles
    // between bytes of one frame restarts the frame with the new byte.
    task automatic test_random();
        int         pos;
        int         gap;
        int         frames;
        logic [7:0] ma, mb, b, exp_res;
        logic [5:0] mop;
        pos = 0; frames = 0; ma = '0; mb = '0;
        for (int ev = 0; ev < 400 && frames < 30; ev++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 2)
                                              : $urandom_range(1, 5);
            idle(gap - 1);
            if (pos > 0 && gap > TO) pos = 0;
            b = 8'($urandom);
            if (pos == 2) b[2:0] = 3'($urandom_range(0, 7)) ^ 3'b000;
            if (pos == 2 && $urandom_range(0, 3) != 0) b[5:3] = 3'b100;
            pulse_rx(b);
            if (pos == 0) begin
                ma = b; pos = 1;
            end else if (pos == 1) begin
                mb = b; pos = 2;
            end else begin
                mop = b[5:0];
                exp_res = alu_f(ma, mb, mop);
                pos = 0;
                frames++;
                n_cmp++;
                if (tx_start !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_early_start: frame %0d start=%b want 0", frames, tx_start);
                end
                step();
                n_cmp++;
                if (tx_start !== 1'b1 || tx_data !== exp_res || data_a !== ma ||
                    data_b !== mb || opcode !== mop) begin
                    n_err++;
                    $display("FAIL rand_frame: frame %0d start=%b data=%h a=%h b=%h op=%h, want 1/%h/%h/%h/%h",
                             frames, tx_start, tx_data, data_a, data_b, opcode, exp_res, ma, mb, mop);
                end
                step();
                if ($urandom_range(0, 1) == 1) begin
                    pulse_rx(8'($urandom));
                    n_cmp++;
                    if (drop !== 1'b1 || data_a !== ma) begin
                        n_err++;
                        $display("FAIL rand_drop: frame %0d drop=%b a=%h, want 1/%h", frames, drop, data_a, ma);
                    end
                end
                idle($urandom_range(0, 4));
                pulse_tx();
                n_cmp++;
                if (busy !== 1'b0 || tx_data !== exp_res) begin
                    n_err++;
                    $display("FAIL rand_done: frame %0d busy=%b data=%h, want 0/%h", frames, busy, tx_data, exp_res);
                end
                $display("frame %0d: a=%h b=%h op=%h -> %h", frames, ma, mb, mop, tx_data);
            end
        end
        n_cmp++;
        if (frames < 30) begin
            n_err++;
            $display("FAIL rand_frame_count: got %0d frames, want 30", frames);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_drop();
        test_timeout();
        test_opcode_trunc();
        test_expiry_edge();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
